// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
// Holds the FSM state encoding and the request word-count saturation rule.
package lsu_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 16;
  localparam int RIDX_W    = 3;
  localparam int MAX_WORDS = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Requests above MAX_WORDS are clipped rather than rejected
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] count);
    if (count > CNT_W'(MAX_WORDS)) begin
      return CNT_W'(MAX_WORDS);
    end else begin
      return count;
    end
  endfunction

endpackage

// File: rtl/lsu_multi_if.sv
// Bundles the request handshake, register-file ports, data-memory port and status.
// The sequencer uses the slave view; the execute stage / memory side uses master.
interface lsu_multi_if;
  import lsu_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_load;
  logic [ADDR_W-1:0]       req_base;
  logic [CNT_W-1:0]        req_count;
  logic [RIDX_W-1:0]       req_rd;

  logic [RIDX_W-1:0]       rf_raddr;
  logic [DATA_W-1:0]       rf_rdata;
  logic                    rf_we;
  logic [RIDX_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;

  logic [ADDR_W-1:0]       mem_adr;
  logic [DATA_W-1:0]       mem_wd;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_rdata;

  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       done_addr;

  modport slave (
    input  req_valid, req_load, req_base, req_count, req_rd, rf_rdata, mem_rdata,
    output req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
           mem_adr, mem_wd, mem_we, busy, done, done_addr
  );

  modport master (
    output req_valid, req_load, req_base, req_count, req_rd, rf_rdata, mem_rdata,
    input  req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
           mem_adr, mem_wd, mem_we, busy, done, done_addr
  );

endinterface

// File: rtl/lsu_multi.sv
// Load/store-multiple sequencer: moves one word per cycle between the register
// file and the data memory, then pulses done with the post-increment address.
module lsu_multi
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  lsu_multi_if.slave  bus
);

  lsu_state_t        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [RIDX_W-1:0] idx_r;
  logic [CNT_W-1:0]  rem_r;
  logic              load_r;
  logic [CNT_W-1:0]  cnt_sat_s;

  assign cnt_sat_s = sat_count(bus.req_count);

  // FSM plus address/index/remaining-count bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      idx_r   <= {RIDX_W{1'b0}};
      rem_r   <= {CNT_W{1'b0}};
      load_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            addr_r  <= bus.req_base;
            idx_r   <= bus.req_rd;
            rem_r   <= cnt_sat_s;
            load_r  <= bus.req_load;
            state_r <= (cnt_sat_s == {CNT_W{1'b0}}) ? DONE : XFER;
          end else begin
            state_r <= IDLE;
          end
        end
        XFER: begin
          // Address and register index both wrap naturally at their widths
          addr_r <= addr_r + ADDR_W'(1'b1);
          idx_r  <= idx_r + RIDX_W'(1'b1);
          rem_r  <= rem_r - CNT_W'(1'b1);
          if (rem_r == CNT_W'(1'b1)) begin
            state_r <= DONE;
          end else begin
            state_r <= XFER;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output steering from the current state; load data passes straight through
  always_comb begin
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.done_addr = {ADDR_W{1'b0}};
    bus.mem_adr   = {ADDR_W{1'b0}};
    bus.mem_wd    = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    bus.rf_raddr  = {RIDX_W{1'b0}};
    bus.rf_we     = 1'b0;
    bus.rf_waddr  = {RIDX_W{1'b0}};
    bus.rf_wdata  = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        bus.req_ready = ~rst;
      end
      XFER: begin
        bus.busy    = 1'b1;
        bus.mem_adr = addr_r;
        if (load_r) begin
          bus.rf_we    = 1'b1;
          bus.rf_waddr = idx_r;
          bus.rf_wdata = bus.mem_rdata;
        end else begin
          bus.mem_we   = 1'b1;
          bus.rf_raddr = idx_r;
          bus.mem_wd   = bus.rf_rdata;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.done      = 1'b1;
        bus.done_addr = addr_r;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_multi.sv
// Directed bench for lsu_multi: a transaction-level model predicts every cycle's
// outputs from each accepted request and is compared against the DUT each cycle.
module tb_lsu_multi;

  typedef struct {
    logic        mem_we;
    logic [12:0] mem_adr;
    logic [15:0] mem_wd;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        chk_raddr;
    logic [2:0]  rf_raddr;
    logic        done;
    logic [12:0] done_addr;
    logic        busy;
    logic        ready;
  } rec_t;

  logic clk;
  logic rst;

  lsu_multi_if bus();

  lsu_multi dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment: data memory and register file the sequencer talks to
  logic [15:0] env_mem [0:8191];
  logic [15:0] env_rf  [0:7];
  logic        pl_en;
  logic [12:0] pl_adr;
  logic [15:0] pl_dat;
  logic        rpl_en;
  logic [2:0]  rpl_adr;
  logic [15:0] rpl_dat;

  assign bus.mem_rdata = bus.mem_we ? 16'h0000 : env_mem[bus.mem_adr];
  assign bus.rf_rdata  = env_rf[bus.rf_raddr];

  always @(posedge clk) begin
    if (bus.mem_we) env_mem[bus.mem_adr] <= bus.mem_wd;
    else if (pl_en) env_mem[pl_adr] <= pl_dat;
  end

  always @(posedge clk) begin
    if (bus.rf_we) env_rf[bus.rf_waddr] <= bus.rf_wdata;
    else if (rpl_en) env_rf[rpl_adr] <= rpl_dat;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: expected contents plus the queue of upcoming cycles
  logic [15:0] exp_mem [0:8191];
  logic [15:0] exp_rf  [0:7];
  rec_t        q[$];
  logic        accepted;

  int          errors = 0;
  int          checks = 0;
  int          mem_we_cnt = 0;
  int          rf_we_cnt = 0;
  int          done_cnt = 0;
  logic        last_done;
  logic        last_busy;
  logic        last_ready;
  logic [12:0] last_done_addr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic compare();
    rec_t e;
    if (q.size() != 0) begin
      e = q[0];
    end else begin
      e = '{mem_we: 1'b0, mem_adr: 13'h0, mem_wd: 16'h0, rf_we: 1'b0, rf_waddr: 3'h0,
            rf_wdata: 16'h0, chk_raddr: 1'b1, rf_raddr: 3'h0, done: 1'b0,
            done_addr: 13'h0, busy: 1'b0, ready: !rst};
    end
    chk("mem_we",   32'(bus.mem_we),    32'(e.mem_we));
    chk("mem_adr",  32'(bus.mem_adr),   32'(e.mem_adr));
    chk("mem_wd",   32'(bus.mem_wd),    32'(e.mem_wd));
    chk("rf_we",    32'(bus.rf_we),     32'(e.rf_we));
    chk("rf_waddr", 32'(bus.rf_waddr),  32'(e.rf_waddr));
    chk("rf_wdata", 32'(bus.rf_wdata),  32'(e.rf_wdata));
    chk("done",     32'(bus.done),      32'(e.done));
    chk("busy",     32'(bus.busy),      32'(e.busy));
    chk("req_ready",32'(bus.req_ready), 32'(e.ready));
    if (e.chk_raddr) chk("rf_raddr", 32'(bus.rf_raddr), 32'(e.rf_raddr));
    if (e.done) chk("done_addr", 32'(bus.done_addr), 32'(e.done_addr));
    mem_we_cnt += int'(bus.mem_we);
    rf_we_cnt  += int'(bus.rf_we);
    done_cnt   += int'(bus.done);
    last_done      = bus.done;
    last_busy      = bus.busy;
    last_ready     = bus.req_ready;
    last_done_addr = bus.done_addr;
  endtask

  // Rising-edge model: retire the finished cycle, then maybe accept a request
  task automatic model_edge();
    rec_t r;
    bit   was_empty;
    int   n;
    int   base;
    accepted = 1'b0;
    if (rst) begin
      q.delete();
      return;
    end
    was_empty = (q.size() == 0);
    if (!was_empty) begin
      r = q.pop_front();
      if (r.mem_we) exp_mem[r.mem_adr] = r.mem_wd;
      if (r.rf_we)  exp_rf[r.rf_waddr] = r.rf_wdata;
    end
    if (was_empty && bus.req_valid) begin
      accepted = 1'b1;
      n = (int'(bus.req_count) > 8) ? 8 : int'(bus.req_count);
      base = int'(bus.req_base);
      for (int k = 0; k < n; k++) begin
        r = '{mem_we: 1'b0, mem_adr: 13'((base + k) % 8192), mem_wd: 16'h0, rf_we: 1'b0,
              rf_waddr: 3'h0, rf_wdata: 16'h0, chk_raddr: 1'b0, rf_raddr: 3'h0,
              done: 1'b0, done_addr: 13'h0, busy: 1'b1, ready: 1'b0};
        if (bus.req_load) begin
          r.rf_we    = 1'b1;
          r.rf_waddr = 3'((int'(bus.req_rd) + k) % 8);
          r.rf_wdata = exp_mem[r.mem_adr];
        end else begin
          r.mem_we    = 1'b1;
          r.chk_raddr = 1'b1;
          r.rf_raddr  = 3'((int'(bus.req_rd) + k) % 8);
          r.mem_wd    = exp_rf[r.rf_raddr];
        end
        q.push_back(r);
      end
      r = '{mem_we: 1'b0, mem_adr: 13'h0, mem_wd: 16'h0, rf_we: 1'b0, rf_waddr: 3'h0,
            rf_wdata: 16'h0, chk_raddr: 1'b1, rf_raddr: 3'h0, done: 1'b1,
            done_addr: 13'((base + n) % 8192), busy: 1'b1, ready: 1'b0};
      q.push_back(r);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic poke_mem(input logic [12:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_adr = a; pl_dat = d; exp_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic poke_rf(input logic [2:0] a, input logic [15:0] d);
    rpl_en = 1'b1; rpl_adr = a; rpl_dat = d; exp_rf[a] = d;
    step();
    rpl_en = 1'b0;
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (accepted) got = 1'b1;
    end
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done(output int lat, output logic [12:0] daddr);
    lat = 0;
    daddr = 13'h0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (last_done) begin
        lat = c;
        daddr = last_done_addr;
        break;
      end
    end
  endtask

  task automatic run_req(input logic ld, input logic [12:0] base, input logic [3:0] cnt,
                         input logic [2:0] rd, output int lat, output logic [12:0] daddr);
    bus.req_load = ld; bus.req_base = base; bus.req_count = cnt; bus.req_rd = rd;
    bus.req_valid = 1'b1;
    wait_accept();
    bus.req_valid = 1'b0;
    wait_done(lat, daddr);
  endtask

  int          lat;
  logic [12:0] daddr;
  int          m0, r0, d0;
  logic [15:0] rfv [0:7];

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_adr = 13'h0; pl_dat = 16'h0;
    rpl_en = 1'b0; rpl_adr = 3'h0; rpl_dat = 16'h0;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_base = 13'h0;
    bus.req_count = 4'h0; bus.req_rd = 3'h0;
    rfv[0] = 16'h0F0F; rfv[1] = 16'h1234; rfv[2] = 16'h2222; rfv[3] = 16'h3333;
    rfv[4] = 16'h4444; rfv[5] = 16'h5A5A; rfv[6] = 16'hAAAA; rfv[7] = 16'h5555;

    // Reset state
    #2;
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_busy",  32'(bus.busy), 32'd0);
    chk("reset_mem_we",32'(bus.mem_we), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Load of three words into r1..r3
    poke_mem(13'h0, 16'd25); poke_mem(13'h1, 16'd20); poke_mem(13'h2, 16'd30);
    m0 = mem_we_cnt; r0 = rf_we_cnt;
    run_req(1'b1, 13'h0, 4'd3, 3'd1, lat, daddr);
    chk("load_lat", 32'(lat), 32'd4);
    chk("load_daddr", 32'(daddr), 32'h3);
    chk("load_rf_writes", 32'(rf_we_cnt - r0), 32'd3);
    chk("load_mem_writes", 32'(mem_we_cnt - m0), 32'd0);
    step();
    chk("load_r1", 32'(env_rf[1]), 32'd25);
    chk("load_r2", 32'(env_rf[2]), 32'd20);
    chk("load_r3", 32'(env_rf[3]), 32'd30);

    // Store two words from r6/r7
    for (int i = 0; i < 8; i++) poke_rf(3'(i), rfv[i]);
    m0 = mem_we_cnt; r0 = rf_we_cnt;
    run_req(1'b0, 13'h100, 4'd2, 3'd6, lat, daddr);
    chk("store_daddr", 32'(daddr), 32'h102);
    chk("store_rf_writes", 32'(rf_we_cnt - r0), 32'd0);
    step();
    chk("store_m100", 32'(env_mem[13'h100]), 32'hAAAA);
    chk("store_m101", 32'(env_mem[13'h101]), 32'h5555);

    // Address and register index wrap
    run_req(1'b0, 13'h1FFF, 4'd3, 3'd7, lat, daddr);
    chk("wrap_daddr", 32'(daddr), 32'h2);
    step();
    chk("wrap_m1fff", 32'(env_mem[13'h1FFF]), 32'h5555);
    chk("wrap_m0000", 32'(env_mem[13'h0000]), 32'h0F0F);
    chk("wrap_m0001", 32'(env_mem[13'h0001]), 32'h1234);

    // Count 0: immediate done, no writes
    m0 = mem_we_cnt; r0 = rf_we_cnt;
    run_req(1'b0, 13'h55, 4'd0, 3'd2, lat, daddr);
    chk("cnt0_lat", 32'(lat), 32'd1);
    chk("cnt0_daddr", 32'(daddr), 32'h55);
    chk("cnt0_writes", 32'((mem_we_cnt - m0) + (rf_we_cnt - r0)), 32'd0);

    // Count 12 saturates to 8 words
    poke_mem(13'h208, 16'hDEAD);
    m0 = mem_we_cnt;
    run_req(1'b0, 13'h200, 4'd12, 3'd0, lat, daddr);
    chk("sat_lat", 32'(lat), 32'd9);
    chk("sat_daddr", 32'(daddr), 32'h208);
    chk("sat_mem_writes", 32'(mem_we_cnt - m0), 32'd8);
    step();
    chk("sat_m200", 32'(env_mem[13'h200]), 32'h0F0F);
    chk("sat_m207", 32'(env_mem[13'h207]), 32'h5555);
    chk("sat_m208", 32'(env_mem[13'h208]), 32'hDEAD);

    // Reset during the second word of a 4-word store
    for (int i = 0; i < 4; i++) poke_mem(13'h40 + 13'(i), 16'h1111);
    d0 = done_cnt;
    bus.req_load = 1'b0; bus.req_base = 13'h40; bus.req_count = 4'd4; bus.req_rd = 3'd2;
    bus.req_valid = 1'b1;
    wait_accept();
    bus.req_valid = 1'b0;
    step();
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_m40", 32'(env_mem[13'h40]), 32'h2222);
    chk("abort_m41", 32'(env_mem[13'h41]), 32'h1111);
    chk("abort_m42", 32'(env_mem[13'h42]), 32'h1111);
    chk("abort_m43", 32'(env_mem[13'h43]), 32'h1111);
    run_req(1'b1, 13'h40, 4'd1, 3'd5, lat, daddr);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_daddr", 32'(daddr), 32'h41);
    step();
    chk("post_rst_r5", 32'(env_rf[5]), 32'h2222);

    // req_valid held high; inputs change after the first accept
    bus.req_load = 1'b1; bus.req_base = 13'h0; bus.req_count = 4'd2; bus.req_rd = 3'd4;
    bus.req_valid = 1'b1;
    wait_accept();
    bus.req_base = 13'h2; bus.req_count = 4'd1; bus.req_rd = 3'd6;
    wait_done(lat, daddr);
    chk("hold_lat1", 32'(lat), 32'd3);
    chk("hold_daddr1", 32'(daddr), 32'h2);
    step();
    chk("hold_gap_busy", 32'(last_busy), 32'd0);
    chk("hold_gap_ready", 32'(last_ready), 32'd1);
    step();
    chk("hold_second_busy", 32'(last_busy), 32'd1);
    bus.req_valid = 1'b0;
    wait_done(lat, daddr);
    chk("hold_daddr2", 32'(daddr), 32'h3);
    step(); step();
    chk("hold_r4", 32'(env_rf[4]), 32'h0F0F);
    chk("hold_r5", 32'(env_rf[5]), 32'h1234);
    chk("hold_r6", 32'(env_rf[6]), 32'h001E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_multi.md
# lsu_multi

Load/store-multiple sequencer between the execute stage and the 8K x 16 data memory. Accepts one block-transfer request (base address, word count, first register index, direction). Moves one 16-bit word per cycle between the register file and memory, then signals completion with the post-increment address. It is the only master of the data memory's adr/WD/WE port.

## Interface
- ADDR_W, 13, memory word-address width (8192 words)
- DATA_W, 16, data width
- RIDX_W, 3, register index width (r0..r7)
- MAX_WORDS, 8, maximum words per request

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and while rst low
- req_load  in  1  1 = memory->registers, 0 = registers->memory
- req_base  in  ADDR_W  first word address
- req_count  in  4  word count: 0 = none, 1..8 = count, 9..15 saturate to 8
- req_rd  in  RIDX_W  first register index
- rf_raddr  out  RIDX_W  register-file read index (store data source)
- rf_rdata  in  DATA_W  combinational register-file read data
- rf_we / rf_waddr / rf_wdata  out  1 / RIDX_W / DATA_W  register-file write port
- mem_adr  out  ADDR_W  to memory adr
- mem_wd  out  DATA_W  to memory WD
- mem_we  out  1  to memory WE
- mem_rdata  in  DATA_W  from memory Memout (combinational; reads 0 while WE=1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- done_addr  out  ADDR_W  base + transferred words, mod 2^ADDR_W

## Operation
- States:
  - IDLE -> XFER on accept with count != 0
  - IDLE -> DONE on accept with count = 0
  - XFER -> DONE when remaining count reaches 0 after the current word
  - DONE -> IDLE unconditionally
- Accept condition: req_valid & req_ready at a rising edge. This latches addr = req_base, idx = req_rd, rem = saturated count, and dir.
- XFER, each cycle, mem_adr = addr:
  - Load: mem_we = 0; rf_we = 1; rf_waddr = idx; rf_wdata = mem_rdata (combinational pass-through).
  - Store: mem_we = 1; rf_raddr = idx; mem_wd = rf_rdata.
  - At the edge: addr += 1 (wraps 0x1FFF -> 0x0000); idx += 1 (wraps r7 -> r0); rem -= 1.
- DONE: done = 1 and done_addr = current addr. No memory or register writes.
- Outside XFER: mem_we = 0, rf_we = 0, mem_adr = 0, mem_wd = 0, rf_wdata = 0.
- req_valid is ignored while busy; request inputs are sampled only at accept.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE; busy = 0; done = 0; done_addr = 0
  - mem_we = 0; rf_we = 0; all address and data outputs 0
  - req_ready = 0 while rst is high
- Accept at edge E0. Word k (k = 0..N-1) is in cycle E0+1+k. The store write commits at the end of that cycle.
- done is high in cycle E0+N+1. req_ready returns in cycle E0+N+2.
- Count 0: done in cycle E0+1, done_addr = req_base, no writes.
- Back-to-back requests: minimum spacing N+2 cycles.
- Reset mid-transfer: words whose edge has passed stay written. The current cycle's write is aborted because mem_we drops asynchronously. No done pulse is generated.

## Structure
- Shared package lsu_pkg holds:
  - state enum: IDLE, XFER, DONE
  - ADDR_W, DATA_W, RIDX_W, MAX_WORDS constants
  - count-saturation function
- Single module, no sub-modules. The FSM and the addr/idx/rem counters live in one sequential block; output muxing is combinational from state.

## Test plan
- Load, memory preloaded [0]=25, [1]=20, [2]=30; base 0, count 3, rd r1 -> rf writes r1=25, r2=20, r3=30 in cycles 1-3; done in cycle 4 with done_addr 3.
- Store, base 0x100, count 2, rd r6, r6=0xAAAA, r7=0x5555 -> mem[0x100]=0xAAAA, mem[0x101]=0x5555; rf_we never high; done_addr 0x102.
- Wrap: store base 0x1FFF, count 3, rd r7 -> addresses 0x1FFF, 0x0000, 0x0001 from r7, r0, r1; done_addr 0x0002.
- Count boundaries: count 0 -> done next cycle, no writes. Count 12 -> exactly 8 words, done_addr = base+8.
- Reset asserted during word 2 of a 4-word store to base 0x40 -> only mem[0x40] changed, mem_we low immediately, done never pulses; after release a load of 1 word is accepted normally.
- req_valid held high through a 2-word load -> second request accepted only in the cycle after done; verify req_ready low during XFER and DONE.
